// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default clocking and baud divisor derivation.
// Used by both uart_tx and uart_rx so the pair always agrees on bit timing.
package uart_pkg;

    localparam int DEFAULT_CLOCK_FREQUENCY = 27_000_000;
    localparam int DEFAULT_BAUD_RATE       = 115_200;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // Integer division: any fractional clocks per bit are dropped.
    function automatic int baud_divisor(input int clock_frequency, input int baud_rate);
        return clock_frequency / baud_rate;
    endfunction

endpackage

// File: rtl/rx_sync.sv
// Serial input synchronizer: two flops into clk domain plus a previous-value flop for edge detection.
// Latency: rx_s follows rx by 2 clocks; fall_edge is valid in the same cycle as the new rx_s.
// Backpressure: none, free-running.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic sync_1;
    logic sync_2;
    logic rx_prev;

    // Reset to 1 so a reset never looks like a start-bit edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b1;
            sync_2  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync_1  <= rx;
            sync_2  <= sync_1;
            rx_prev <= sync_2;
        end
    end

    assign rx_s      = sync_2;
    assign fall_edge = rx_prev & ~sync_2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver presenting each byte on a valid/ready holding register.
// Latency: byte is valid 3 + HALF_DIVISOR + 9*BAUD_DIVISOR clocks after the rx falling edge.
// Backpressure: one-byte holding register; a byte completing while it is full and not accepted is dropped with an overrun pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = DEFAULT_CLOCK_FREQUENCY,
    parameter int BAUD_RATE       = DEFAULT_BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       framing_error,
    output logic       overrun
);

    localparam int BAUD_DIVISOR = baud_divisor(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF_DIVISOR = BAUD_DIVISOR / 2;
    localparam int CNT_W        = $clog2(BAUD_DIVISOR);

    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(BAUD_DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(HALF_DIVISOR - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             rx_s;
    logic             fall_edge;
    uart_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;

    rx_sync u_rx_sync (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_s      (rx_s),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            data          <= '0;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;

            // Consumer handshake; a delivery in the same cycle overrides below.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (fall_edge) begin
                        state    <= START;
                        baud_cnt <= HALF_RELOAD;
                    end
                end

                START: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else if (!rx_s) begin
                        state    <= DATA;
                        baud_cnt <= BAUD_RELOAD;
                        bit_cnt  <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end

                DATA: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else begin
                        shift_reg <= {rx_s, shift_reg[7:1]};
                        baud_cnt  <= BAUD_RELOAD;
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end

                STOP: begin
                    if (baud_cnt != '0) begin
                        baud_cnt <= baud_cnt - CNT_ONE;
                    end else begin
                        // Back to IDLE either way: a held-low line needs a fresh edge.
                        state <= IDLE;
                        if (rx_s) begin
                            if (!valid || ready) begin
                                data  <= shift_reg;
                                valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at default 27 MHz / 115200 baud.
module tb_uart_rx;

    localparam int BIT_CLKS = 234;
    // 2 sync flops + IDLE->START edge, then HALF_DIVISOR + 9 * BAUD_DIVISOR.
    localparam int DELIVERY_EDGE = 3 + 117 + 9 * 234;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       framing_error;
    logic       overrun;

    int n_checks  = 0;
    int n_errors  = 0;
    int vld_rises = 0;
    int fe_cnt    = 0;
    int ov_cnt    = 0;
    int stab_err  = 0;

    logic       prev_valid = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .data          (data),
        .valid         (valid),
        .ready         (ready),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    // Pulse counters and hold-stability watch, sampled just after each edge.
    always @(posedge clk) begin
        #1;
        if (valid === 1'b1 && prev_valid !== 1'b1) vld_rises++;
        if (framing_error === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
        if (rst === 1'b0 && prev_valid === 1'b1 && ready === 1'b0 && data !== prev_data) stab_err++;
        prev_valid = valid;
        prev_data  = data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Call at a negedge; returns at a negedge with rx left at the stop value.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic measure_latency(output int lat, output logic [7:0] d);
        logic got;
        got = 1'b0;
        lat = 0;
        d   = 8'h00;
        while (!got && lat < 3000) begin
            @(posedge clk);
            lat++;
            #1;
            if (valid === 1'b1) begin
                got = 1'b1;
                d   = data;
            end
        end
    endtask

    initial begin
        int         lat;
        logic [7:0] d0;
        int         b_rise, b_fe, b_ov;

        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_framing_error", framing_error, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 0x54 with ready held high: single valid cycle, bounded latency.
        ready  = 1'b1;
        b_rise = vld_rises; b_fe = fe_cnt; b_ov = ov_cnt;
        fork
            send_frame(8'h54, 1'b1);
            measure_latency(lat, d0);
        join
        repeat (5) @(negedge clk);
        check("t1_latency_window", (lat >= 2220 && lat <= 2226), 1'b1);
        check("t1_data", d0, 8'h54);
        check("t1_valid_rises", vld_rises - b_rise, 1);
        check("t1_valid_cleared", valid, 1'b0);
        check("t1_no_framing", fe_cnt - b_fe, 0);
        check("t1_no_overrun", ov_cnt - b_ov, 0);

        // 50-clock low glitch: false start, nothing reported.
        b_rise = vld_rises; b_fe = fe_cnt; b_ov = ov_cnt;
        rx = 1'b0;
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        check("t2_no_valid", vld_rises - b_rise, 0);
        check("t2_no_framing", fe_cnt - b_fe, 0);
        check("t2_no_overrun", ov_cnt - b_ov, 0);

        // 0xA5 with low stop bit, then break for three bit times: one framing error.
        ready = 1'b0;
        b_fe  = fe_cnt; b_ov = ov_cnt;
        send_frame(8'hA5, 1'b0);
        repeat (3 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (BIT_CLKS) @(negedge clk);
        check("t3_one_framing_error", fe_cnt - b_fe, 1);
        check("t3_valid_low", valid, 1'b0);
        send_frame(8'h0D, 1'b1);
        repeat (10) @(negedge clk);
        check("t3_recover_valid", valid, 1'b1);
        check("t3_recover_data", data, 8'h0D);
        check("t3_no_overrun", ov_cnt - b_ov, 0);

        // 0x0A arrives while 0x0D held; ready only in the delivery cycle.
        b_rise = vld_rises; b_ov = ov_cnt;
        fork
            send_frame(8'h0A, 1'b1);
            begin
                repeat (DELIVERY_EDGE - 1) @(posedge clk);
                @(negedge clk) ready = 1'b1;
                @(negedge clk) ready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("t5_valid_kept", valid, 1'b1);
        check("t5_data", data, 8'h0A);
        check("t5_no_overrun", ov_cnt - b_ov, 0);
        check("t5_no_new_rise", vld_rises - b_rise, 0);

        // Reset mid-DATA of 0xFF while 0x0A is held, then 0x65.
        b_fe = fe_cnt; b_ov = ov_cnt;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (600) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        check("t6_rst_valid", valid, 1'b0);
        check("t6_rst_data", data, 8'h00);
        check("t6_no_framing", fe_cnt - b_fe, 0);
        check("t6_no_overrun", ov_cnt - b_ov, 0);
        send_frame(8'h65, 1'b1);
        repeat (10) @(negedge clk);
        check("t6_after_valid", valid, 1'b1);
        check("t6_after_data", data, 8'h65);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check("t6_consumed", valid, 1'b0);

        // Back-to-back 0x31, 0x32 with ready low: 0x31 held, one overrun.
        b_fe = fe_cnt; b_ov = ov_cnt;
        send_frame(8'h31, 1'b1);
        send_frame(8'h32, 1'b1);
        repeat (10) @(negedge clk);
        check("t4_valid", valid, 1'b1);
        check("t4_data_held", data, 8'h31);
        check("t4_one_overrun", ov_cnt - b_ov, 1);
        check("t4_no_framing", fe_cnt - b_fe, 0);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check("t4_consumed", valid, 1'b0);

        check("data_stable_while_held", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
